// File: rtl/rsa_byte_sequencer.sv
// Upstream feeder for the RSA core: range-checked byte FIFO, one core launch per byte,
// timeout recovery, and a valid/ready result port with a round-trip match flag.
module rsa_byte_sequencer #(
  parameter int DEPTH   = 8,
  parameter int N       = 21,
  parameter int TIMEOUT = 1023,
  parameter int GAP     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   core_start,
  output logic [7:0]             core_data,
  input  logic [7:0]             core_enc,
  input  logic [7:0]             core_dec,
  input  logic                   core_done,
  output logic [7:0]             out_enc,
  output logic [7:0]             out_dec,
  output logic                   out_match,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_range,
  output logic                   err_timeout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(((TIMEOUT > GAP) ? TIMEOUT : GAP) + 1);
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [AW:0]   FULL     = DEPTH[AW:0];
  localparam logic [8:0]    N_LIM    = N[8:0];
  localparam logic [CW-1:0] TO_LAST  = TIMEOUT[CW-1:0];
  localparam logic [CW-1:0] GAP_LAST = GAP_M1[CW-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_EMIT,
    S_RECOVER
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_core_data;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_out_enc, r_out_dec;
  logic          r_out_match, r_err_range, r_err_timeout;

  logic w_xfer, w_in_ok, w_push, w_pop;
  logic w_capture, w_timeout, w_cnt_clr, w_cnt_inc, w_start, w_valid;

  assign in_ready = !rst && (r_count != FULL);
  assign w_xfer   = in_valid && in_ready;
  assign w_in_ok  = {1'b0, in_data} < N_LIM;
  // A full FIFO deasserts in_ready, so a same-cycle pop never makes room for a push.
  assign w_push   = w_xfer && w_in_ok;

  // NOTE: storage has no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // NOTE: every sequential block uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: defaults first so no path through the case can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_start   = 1'b0;
    w_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_start   = 1'b1;
        w_cnt_clr = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        w_start   = 1'b1;
        w_cnt_inc = 1'b1;
        if (core_done) begin
          w_capture = 1'b1;
          w_next    = S_EMIT;
        end else if (r_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = S_RECOVER;
        end
      end
      S_EMIT: begin
        w_start = 1'b1;
        w_valid = 1'b1;
        if (out_ready) begin
          w_cnt_clr = 1'b1;
          w_next    = S_RECOVER;
        end
      end
      S_RECOVER: begin
        // Leave only after the minimum gap and once the core has dropped done.
        if (r_cnt < GAP_LAST)  w_cnt_inc = 1'b1;
        else if (!core_done)   w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_data   <= '0;
      r_cnt         <= '0;
      r_out_enc     <= '0;
      r_out_dec     <= '0;
      r_out_match   <= 1'b0;
      r_err_range   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_pop) r_core_data <= r_mem[r_rd_ptr];
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_capture) begin
        r_out_enc   <= core_enc;
        r_out_dec   <= core_dec;
        r_out_match <= (core_dec == r_core_data);
      end
      r_err_range   <= w_xfer && !w_in_ok;
      r_err_timeout <= w_timeout;
    end
  end

  assign core_start  = w_start;
  assign core_data   = r_core_data;
  assign out_valid   = w_valid;
  assign out_enc     = r_out_enc;
  assign out_dec     = r_out_dec;
  assign out_match   = r_out_match;
  assign err_range   = r_err_range;
  assign err_timeout = r_err_timeout;
  assign fifo_count  = r_count;
  assign busy        = (r_state != S_IDLE) || (r_count != '0);

endmodule
